// File: rtl/radix_4_divider_if.sv
// Handshake and operand/result bundle for the radix-4 divider.
// The requester uses the master view; the divider uses the slave view.
interface radix_4_divider_if #(
  parameter int N = 12
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/radix_4_divider.sv
// Sequential unsigned radix-4 restoring divider: two quotient bits per clock.
// Accepts an operation from IDLE, iterates N/2 times in CALC, then presents
// registered results with a one-cycle done pulse in DONE. Results hold until
// the next operation reaches DONE or until reset.
module radix_4_divider #(
  parameter int N = 12
) (
  input logic             clk,
  input logic             rst,
  radix_4_divider_if.slave bus
);
  localparam int CW = $clog2(N / 2 + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [N+1:0]  p;       // partial remainder
  logic [N-1:0]  a;       // dividend shift register
  logic [N-1:0]  d;       // latched divisor
  logic [N-1:0]  qacc;    // quotient accumulator
  logic [CW-1:0] cnt;     // iterations still to run

  logic          busy_r;
  logic          done_r;
  logic          dbz_r;
  logic [N-1:0]  quot_r;
  logic [N-1:0]  rem_r;

  logic [N+1:0]  pt;
  logic [N+1:0]  d1;
  logic [N+1:0]  d2;
  logic [N+1:0]  d3;
  logic [N+1:0]  p_next;
  logic [1:0]    qd;
  logic [N-1:0]  q_next;

  // One radix-4 step: pick the largest multiple of D that fits under Pt.
  // Pt < 4D always holds, so 3 is the largest digit ever needed.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    qd     = 2'd0;
    pt     = (p << 2) | {{N{1'b0}}, a[N-1:N-2]};
    d1     = {2'b00, d};
    d2     = {1'b0, d, 1'b0};
    d3     = d1 + d2;
    p_next = pt;
    if (pt >= d3) begin
      qd     = 2'd3;
      p_next = pt - d3;
    end else if (pt >= d2) begin
      qd     = 2'd2;
      p_next = pt - d2;
    end else if (pt >= d1) begin
      qd     = 2'd1;
      p_next = pt - d1;
    end
    q_next = (qacc << 2) | {{(N-2){1'b0}}, qd};
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state  <= IDLE;
      p      <= '0;
      a      <= '0;
      d      <= '0;
      qacc   <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a      <= bus.dividend;
            d      <= bus.divisor;
            p      <= '0;
            qacc   <= '0;
            cnt    <= CW'(N / 2);
            busy_r <= 1'b1;
            if (bus.divisor == '0) begin
              // Divide by zero skips CALC and reports immediately.
              state  <= DONE;
              done_r <= 1'b1;
              quot_r <= '1;
              rem_r  <= bus.dividend;
              dbz_r  <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          p    <= p_next;
          a    <= a << 2;
          qacc <= q_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= DONE;
            done_r <= 1'b1;
            quot_r <= q_next;
            rem_r  <= p_next[N-1:0];
            dbz_r  <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule
